// File: rtl/lfu_input_arbiter.sv
// Button front end for the LFU: synchronizes and debounces b1..b4, queues presses per button,
// and grants one queued press per timer tick as a registered one-hot request, round-robin.
module lfu_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PEND_W          = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic       tick,
  output logic       r1,
  output logic       r2,
  output logic       r3,
  output logic       r4,
  output logic       req_valid,
  output logic [1:0] grant_id,
  output logic       overflow
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {IDLE, GRANT} state_t;

  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        db_q, db_prev_q;
  logic [CNT_W-1:0]  db_cnt_q [4];
  logic [PEND_W-1:0] pend_q [4];
  logic [3:0]        press;
  logic [3:0]        grant_dec;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] r_q, r_d;
  logic [1:0] gid_q, gid_d;
  logic       rv_q, rv_d;
  logic       ovf_q;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Two-flop synchronizer, then a per-button stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {b4, b3, b2, b1};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  // A press and a grant on the same button cancel, which also covers the saturated case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pend_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (press[i] && !grant_dec[i]) begin
          if (pend_q[i] == PEND_MAX) ovf_q     <= 1'b1;
          else                       pend_q[i] <= pend_q[i] + 1'b1;
        end else if (!press[i] && grant_dec[i]) begin
          pend_q[i] <= pend_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      r_q     <= '0;
      gid_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      r_q     <= r_d;
      gid_q   <= gid_d;
      rv_q    <= rv_d;
    end
  end

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    state_d   = state_q;
    ptr_d     = ptr_q;
    r_d       = r_q;
    gid_d     = gid_q;
    rv_d      = rv_q;
    grant_dec = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && pend_q[cand] != '0) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (tick) begin
      if (win_found) begin
        state_d            = GRANT;
        ptr_d              = win_idx;
        r_d                = 4'b0001 << win_idx;
        gid_d              = win_idx;
        rv_d               = 1'b1;
        grant_dec[win_idx] = 1'b1;
      end else begin
        state_d = IDLE;
        r_d     = '0;
        gid_d   = '0;
        rv_d    = 1'b0;
      end
    end
  end

  assign {r4, r3, r2, r1} = r_q;
  assign req_valid        = rv_q;
  assign grant_id         = gid_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_lfu_input_arbiter.sv
// Directed bench for lfu_input_arbiter: reset, single press, bounce rejection, round-robin,
// saturation/overflow and asynchronous reset mid-grant.
module tb_lfu_input_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       b1, b2, b3, b4;
  logic       tick;
  logic       r1, r2, r3, r4;
  logic       req_valid;
  logic [1:0] grant_id;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;

  lfu_input_arbiter #(.DEBOUNCE_CYCLES(4), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .tick(tick),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .req_valid(req_valid), .grant_id(grant_id), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    clk_n(1);
    tick = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] m);
    {b4, b3, b2, b1} = m;
  endtask

  // Hold the given buttons for hold clocks, then release for rel clocks.
  task automatic press(input logic [3:0] m, input int hold, input int rel);
    set_btn(m);
    clk_n(hold);
    set_btn(4'b0000);
    clk_n(rel);
  endtask

  task automatic chk(input string tag, input logic [3:0] r_exp, input logic [1:0] gid_exp,
                     input logic rv_exp, input logic ov_exp);
    logic [7:0] obs, exp;
    obs = {overflow, req_valid, grant_id, r4, r3, r2, r1};
    exp = {ov_exp, rv_exp, gid_exp, r_exp};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {ov,rv,gid,r4..r1}=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    {b4, b3, b2, b1} = 4'bxxxx;
    clk_n(1);
    chk("reset_during_1", 4'b0000, 2'd0, 1'b0, 1'b0);
    clk_n(1);
    chk("reset_during_2", 4'b0000, 2'd0, 1'b0, 1'b0);
    set_btn(4'b0000);
    rst = 1'b0;
    clk_n(3);
    chk("reset_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single press on b1.
    press(4'b0001, 10, 10);
    do_tick();
    chk("b1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    clk_n(7);
    chk("b1_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    do_tick();
    chk("b1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Bouncing b2 never settles long enough to register.
    for (int i = 0; i < 12; i++) begin
      b2 = ~b2;
      clk_n(1);
    end
    b2 = 1'b0;
    clk_n(10);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk($sformatf("bounce_tick%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
      clk_n(3);
    end

    // Fresh reset so b1 has first priority, then three simultaneous presses.
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    clk_n(2);
    press(4'b1101, 10, 10);
    do_tick();
    chk("rr_tick0", 4'b0001, 2'd0, 1'b1, 1'b0);
    clk_n(3);
    do_tick();
    chk("rr_tick1", 4'b0100, 2'd2, 1'b1, 1'b0);
    clk_n(3);
    do_tick();
    chk("rr_tick2", 4'b1000, 2'd3, 1'b1, 1'b0);
    clk_n(3);
    do_tick();
    chk("rr_tick3", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Four presses on b2 against a 2-bit counter: the fourth is dropped.
    for (int i = 0; i < 3; i++) press(4'b0010, 8, 8);
    chk("sat_no_ovf", 4'b0000, 2'd0, 1'b0, 1'b0);
    press(4'b0010, 8, 8);
    chk("sat_ovf", 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk($sformatf("sat_tick%0d", i), 4'b0010, 2'd1, 1'b1, 1'b1);
      clk_n(3);
    end
    do_tick();
    chk("sat_tick3", 4'b0000, 2'd0, 1'b0, 1'b1);

    // Reset in the middle of a b3 grant drops outputs without a clock edge.
    press(4'b0100, 10, 10);
    do_tick();
    chk("b3_grant", 4'b0100, 2'd2, 1'b1, 1'b1);
    clk_n(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    clk_n(1);
    rst = 1'b0;
    clk_n(2);
    do_tick();
    chk("post_reset_tick", 4'b0000, 2'd0, 1'b0, 1'b0);
    press(4'b0001, 10, 10);
    do_tick();
    chk("post_reset_b1", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
